imem_loader: RTL

- Writer side of the instruction-memory read path: streams a program image into instruction memory before the pipeline fetches from it.
- Accepts a byte stream with a valid/ready handshake.
- Packs the bytes into big-endian 32-bit instruction words and issues single-cycle writes to the instruction memory write port.
- Holds the processor (PC and pipeline registers) in reset until a complete, checksum-verified image has been loaded.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR_ST
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words; flags the word on its last byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // The last byte is not stored; it completes the word combinationally.
  assign word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift, byte_data};

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (byte_valid) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[15:0], byte_data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length/payload/checksum frame into instruction memory and releases the CPU once verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [LEN_W-1:0]  words_loaded
);

  // state  | meaning
  // LEN_HI | waiting for upper byte of word count
  // LEN_LO | waiting for lower byte of word count
  // DATA   | receiving payload bytes, writing each completed word
  // CSUM   | waiting for checksum byte
  // DONE   | image verified, CPU released
  // ERR_ST | length or checksum error, CPU held

  state_t             state, state_next;
  logic [7:0]         len_hi_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_n;
  logic [7:0]         csum;
  logic               xfer;
  logic               restart_go;
  logic               word_valid;
  logic [31:0]        word;
  logic               last_word;

  assign xfer       = in_valid && in_ready;
  assign len_n      = {len_hi_q, in_data};
  assign restart_go = restart && (state == DONE || state == ERR_ST);
  assign last_word  = word_valid && ((words_loaded + 16'd1) == len_q);

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart_go),
    .byte_valid (xfer && (state == DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= LEN_HI;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LEN_HI: if (xfer) state_next = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (32'(len_n) > DEPTH) state_next = ERR_ST;
          else if (len_n == '0)   state_next = CSUM;
          else                    state_next = DATA;
        end
      end
      DATA:   if (last_word) state_next = CSUM;
      CSUM:   if (xfer) state_next = (in_data == csum) ? DONE : ERR_ST;
      DONE,
      ERR_ST: if (restart) state_next = LEN_HI;
      default: state_next = LEN_HI;
    endcase
  end

  // Status outputs follow the next state so they are valid in the same cycle the state is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready     <= 1'b1;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= BASE_ADDR;
      im_wdata     <= '0;
      words_loaded <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      csum         <= '0;
    end else begin
      in_ready  <= (state_next != DONE) && (state_next != ERR_ST);
      cpu_hold  <= (state_next != DONE);
      load_done <= (state_next == DONE);
      load_err  <= (state_next == ERR_ST);
      im_we     <= word_valid;

      if (word_valid) begin
        im_wdata     <= word;
        im_addr      <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
        words_loaded <= words_loaded + 16'd1;
      end

      if (xfer && state == LEN_HI) len_hi_q <= in_data;
      if (xfer && state == LEN_LO) len_q    <= len_n;
      if (xfer && state == DATA)   csum     <= csum ^ in_data;

      if (restart_go) begin
        words_loaded <= '0;
        csum         <= '0;
      end
    end
  end

endmodule
